// File: rtl/download_mem_arbiter.sv
// download_mem_arbiter: arbitrates the single external memory port between the
// download stream (buffered in a small FIFO so it never stalls) and the Z80
// CPU bus. The CPU is held in wait while downloading or while buffered bytes
// remain. It receives a fixed-length reset pulse once a download ends.
module download_mem_arbiter #(
    parameter int FIFO_AW      = 2,
    parameter int RESET_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        dl_downloading,
    input  logic        dl_wr,
    input  logic [24:0] dl_addr,
    input  logic [7:0]  dl_data,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [24:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    output logic        cpu_ack,
    output logic [7:0]  cpu_dout,
    output logic        cpu_wait,
    output logic        cpu_reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [24:0] mem_addr,
    output logic [7:0]  mem_din,
    input  logic [7:0]  mem_dout,
    input  logic        mem_ack,
    output logic        dl_overflow
);

    localparam int                DEPTH    = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]  PTR_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
    localparam logic [7:0]        RST_LOAD = 8'(RESET_CYCLES);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DL_ACC   = 3'd1,
        CPU_ACC  = 3'd2,
        GAP      = 3'd3,
        RST_HOLD = 3'd4
    } state_t;

    state_t             state_r, state_s;
    logic [32:0]        fifo_mem_r [DEPTH];
    logic [FIFO_AW:0]   wr_ptr_r, rd_ptr_r;
    logic               empty_s, full_s, push_s, pop_s, drop_s;
    logic [32:0]        head_s;
    logic               dl_prev_r, dl_rise_s, dl_fall_s;
    logic               pending_r, rst_done_s;
    logic [7:0]         rst_cnt_r, rst_cnt_s;
    logic               ovf_r;

    logic               mem_req_r, mem_req_s;
    logic               mem_we_r, mem_we_s;
    logic [24:0]        mem_addr_r, mem_addr_s;
    logic [7:0]         mem_din_r, mem_din_s;
    logic               cpu_ack_r, cpu_ack_s;
    logic [7:0]         cpu_dout_r, cpu_dout_s;
    logic               cpu_wait_r, cpu_wait_s;
    logic               cpu_reset_r, cpu_reset_s;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty_s   = (wr_ptr_r == rd_ptr_r);
    assign full_s    = (wr_ptr_r[FIFO_AW] != rd_ptr_r[FIFO_AW]) &&
                       (wr_ptr_r[FIFO_AW-1:0] == rd_ptr_r[FIFO_AW-1:0]);
    assign pop_s     = (state_r == DL_ACC) && mem_ack;
    assign push_s    = dl_wr && (!full_s || pop_s);
    assign drop_s    = dl_wr && full_s && !pop_s;
    assign head_s    = fifo_mem_r[rd_ptr_r[FIFO_AW-1:0]];
    assign dl_rise_s = dl_downloading && !dl_prev_r;
    assign dl_fall_s = !dl_downloading && dl_prev_r;

    // The falling edge is folded in so the hold-off never dips between the
    // end of a download and the start of the CPU reset pulse.
    assign cpu_wait_s = dl_downloading || !empty_s || (state_r == DL_ACC) ||
                        (state_r == RST_HOLD) || pending_r || dl_fall_s;

    // Download FIFO storage and pointers; a simultaneous pop frees room for a push.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem_r[i] <= 33'd0;
            end
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r[FIFO_AW-1:0]] <= {dl_addr, dl_data};
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Download edge tracking, sticky overflow flag and pending CPU reset request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dl_prev_r <= 1'b0;
            ovf_r     <= 1'b0;
            pending_r <= 1'b0;
        end else begin
            dl_prev_r <= dl_downloading;
            if (drop_s) begin
                ovf_r <= 1'b1;
            end else if (dl_rise_s) begin
                ovf_r <= 1'b0;
            end
            if (dl_fall_s) begin
                pending_r <= 1'b1;
            end else if (rst_done_s) begin
                pending_r <= 1'b0;
            end
        end
    end

    // Next-state and next-output decode; downloads win over the CPU in IDLE.
    always_comb begin
        state_s     = state_r;
        mem_req_s   = mem_req_r;
        mem_we_s    = mem_we_r;
        mem_addr_s  = mem_addr_r;
        mem_din_s   = mem_din_r;
        cpu_ack_s   = 1'b0;
        cpu_dout_s  = cpu_dout_r;
        cpu_reset_s = cpu_reset_r;
        rst_cnt_s   = rst_cnt_r;
        rst_done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (!empty_s) begin
                    state_s                 = DL_ACC;
                    mem_req_s               = 1'b1;
                    mem_we_s                = 1'b1;
                    {mem_addr_s, mem_din_s} = head_s;
                end else if (pending_r) begin
                    state_s     = RST_HOLD;
                    cpu_reset_s = 1'b1;
                    rst_cnt_s   = RST_LOAD;
                end else if (cpu_req && !cpu_wait_r) begin
                    state_s    = CPU_ACC;
                    mem_req_s  = 1'b1;
                    mem_we_s   = cpu_we;
                    mem_addr_s = cpu_addr;
                    mem_din_s  = cpu_din;
                end else begin
                    state_s = IDLE;
                end
            end
            DL_ACC: begin
                if (mem_ack) begin
                    mem_req_s = 1'b0;
                    state_s   = GAP;
                end else begin
                    state_s = DL_ACC;
                end
            end
            CPU_ACC: begin
                if (mem_ack) begin
                    mem_req_s  = 1'b0;
                    cpu_ack_s  = 1'b1;
                    cpu_dout_s = mem_dout;
                    state_s    = GAP;
                end else begin
                    state_s = CPU_ACC;
                end
            end
            GAP: begin
                mem_req_s = 1'b0;
                if (pending_r && empty_s) begin
                    state_s     = RST_HOLD;
                    cpu_reset_s = 1'b1;
                    rst_cnt_s   = RST_LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            RST_HOLD: begin
                mem_req_s = 1'b0;
                if (dl_fall_s) begin
                    rst_cnt_s = RST_LOAD;
                end else if (dl_downloading) begin
                    rst_cnt_s = rst_cnt_r;
                end else if (rst_cnt_r <= 8'd1) begin
                    state_s     = IDLE;
                    cpu_reset_s = 1'b0;
                    rst_done_s  = 1'b1;
                end else begin
                    rst_cnt_s = rst_cnt_r - 8'd1;
                end
            end
            default: begin
                state_s     = IDLE;
                mem_req_s   = 1'b0;
                cpu_reset_s = 1'b0;
            end
        endcase
    end

    // State and registered output update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            rst_cnt_r   <= 8'd0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 25'd0;
            mem_din_r   <= 8'd0;
            cpu_ack_r   <= 1'b0;
            cpu_dout_r  <= 8'd0;
            cpu_wait_r  <= 1'b0;
            cpu_reset_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            rst_cnt_r   <= rst_cnt_s;
            mem_req_r   <= mem_req_s;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_din_r   <= mem_din_s;
            cpu_ack_r   <= cpu_ack_s;
            cpu_dout_r  <= cpu_dout_s;
            cpu_wait_r  <= cpu_wait_s;
            cpu_reset_r <= cpu_reset_s;
        end
    end

    assign mem_req     = mem_req_r;
    assign mem_we      = mem_we_r;
    assign mem_addr    = mem_addr_r;
    assign mem_din     = mem_din_r;
    assign cpu_ack     = cpu_ack_r;
    assign cpu_dout    = cpu_dout_r;
    assign cpu_wait    = cpu_wait_r;
    assign cpu_reset   = cpu_reset_r;
    assign dl_overflow = ovf_r;

endmodule

// File: tb/tb_download_mem_arbiter.sv
// Scoreboard bench for download_mem_arbiter: expected memory requests and CPU
// read data are queued by the stimulus; monitors pop and compare them.
module tb_download_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        dl_downloading, dl_wr;
    logic [24:0] dl_addr;
    logic [7:0]  dl_data;
    logic        cpu_req, cpu_we;
    logic [24:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic        cpu_ack;
    logic [7:0]  cpu_dout;
    logic        cpu_wait, cpu_reset;
    logic        mem_req, mem_we;
    logic [24:0] mem_addr;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic        mem_ack;
    logic        dl_overflow;

    int          n_vec = 0;
    int          n_err = 0;

    logic [33:0] exp_mem [$];
    logic [7:0]  exp_cpu [$];

    bit          resp_on = 1'b0;
    bit          ack_en  = 1'b0;
    int          ack_delay = 3;
    logic [7:0]  rd_val = 8'h00;

    logic [7:0]  bdata [4] = '{8'hF3, 8'hAF, 8'h11, 8'h22};

    download_mem_arbiter #(.FIFO_AW(2), .RESET_CYCLES(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .dl_downloading(dl_downloading), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_ack(cpu_ack), .cpu_dout(cpu_dout), .cpu_wait(cpu_wait), .cpu_reset(cpu_reset),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_ack(mem_ack), .dl_overflow(dl_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory model: random activity during reset, then acks ack_delay cycles after a request.
    initial begin
        mem_ack  = 1'b0;
        mem_dout = 8'h00;
        while (!resp_on) begin
            @(negedge clk);
            mem_ack  = 1'($urandom);
            mem_dout = 8'($urandom);
        end
        mem_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_n && mem_req && ack_en) begin
                repeat (ack_delay - 1) @(negedge clk);
                mem_dout = rd_val;
                mem_ack  = 1'b1;
                @(negedge clk);
                mem_ack  = 1'b0;
            end
        end
    end

    // Memory request monitor: each new request must match the queue head and stay stable.
    initial begin
        logic        req_prev;
        logic [33:0] held;
        req_prev = 1'b0;
        held     = 34'd0;
        forever begin
            @(negedge clk);
            if (reset_n && mem_req && !req_prev) begin
                if (exp_mem.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL mem_unexpected: got we=%0d addr=%h din=%h expected no request",
                             mem_we, mem_addr, mem_din);
                end else begin
                    check("mem_req", {mem_we, mem_addr, mem_din}, exp_mem.pop_front());
                end
                held = {mem_we, mem_addr, mem_din};
            end else if (reset_n && mem_req && req_prev) begin
                check("mem_hold", {mem_we, mem_addr, mem_din}, held);
            end
            req_prev = mem_req;
        end
    end

    // CPU response monitor: one-cycle ack carrying the expected read data.
    initial begin
        logic ack_prev;
        ack_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (cpu_ack) begin
                if (ack_prev) begin
                    check("cpu_ack_len", 64'd2, 64'd1);
                end else if (exp_cpu.size() == 0) begin
                    check("cpu_unexpected_ack", 64'd1, 64'd0);
                end else begin
                    check("cpu_dout", cpu_dout, exp_cpu.pop_front());
                end
            end
            ack_prev = cpu_ack;
        end
    end

    task automatic wait_mem_idle(input string name, input int max, output bit wait_high);
        int g;
        g = 0;
        wait_high = 1'b1;
        while ((exp_mem.size() != 0 || mem_req) && g < max) begin
            if (!cpu_wait) wait_high = 1'b0;
            @(negedge clk);
            g++;
        end
        check({name, "_drained"}, exp_mem.size(), 0);
        check({name, "_req_low"}, mem_req, 1'b0);
    endtask

    task automatic measure_pulse(input string name, input int exp_len, output int q_at_start);
        int g, n;
        bit wait_ok, req_ok;
        g = 0;
        while (!cpu_reset && g < 300) begin
            @(negedge clk);
            g++;
        end
        q_at_start = exp_mem.size();
        n = 0;
        wait_ok = 1'b1;
        req_ok  = 1'b1;
        while (cpu_reset && n < 300) begin
            if (!cpu_wait) wait_ok = 1'b0;
            if (mem_req) req_ok = 1'b0;
            n++;
            @(negedge clk);
        end
        check({name, "_len"}, n, exp_len);
        check({name, "_wait"}, wait_ok, 1'b1);
        check({name, "_no_req"}, req_ok, 1'b1);
    endtask

    task automatic wait_cpu_ack(input string name, input int max);
        int g;
        g = 0;
        while (!cpu_ack && g < max) begin
            @(negedge clk);
            g++;
        end
        check({name, "_ack_seen"}, cpu_ack, 1'b1);
    endtask

    initial begin
        bit wok;
        int qlen, g;
        reset_n = 1'b0;
        dl_downloading = 1'b0; dl_wr = 1'b0; dl_addr = 25'd0; dl_data = 8'd0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 25'd0; cpu_din = 8'd0;

        // Reset: toggle every input, all outputs must stay 0.
        repeat (2) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            dl_downloading = 1'($urandom); dl_wr = 1'($urandom);
            dl_addr = 25'($urandom); dl_data = 8'($urandom);
            cpu_req = 1'($urandom); cpu_we = 1'($urandom);
            cpu_addr = 25'($urandom); cpu_din = 8'($urandom);
            @(negedge clk);
            check("reset_outputs", {cpu_ack, cpu_dout, cpu_wait, cpu_reset, mem_req, mem_we,
                                    mem_addr, mem_din, dl_overflow}, 64'd0);
        end
        dl_downloading = 1'b0; dl_wr = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        dl_addr = 25'd0; dl_data = 8'd0; cpu_addr = 25'd0; cpu_din = 8'd0;
        resp_on = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_reset_wait", cpu_wait, 1'b0);
        check("post_reset_req", mem_req, 1'b0);
        check("post_reset_cpu_reset", cpu_reset, 1'b0);

        // Download burst of four bytes, ack 3 cycles after each request.
        ack_en = 1'b1; ack_delay = 3;
        dl_downloading = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dl_wr = 1'b1; dl_addr = 25'(i); dl_data = bdata[i];
            exp_mem.push_back({1'b1, 25'(i), bdata[i]});
            @(negedge clk);
        end
        dl_wr = 1'b0;
        wait_mem_idle("burst", 300, wok);
        check("burst_wait_high", wok, 1'b1);
        check("burst_overflow", dl_overflow, 1'b0);

        // Tail pointer writes with a slow memory.
        ack_delay = 10;
        dl_wr = 1'b1; dl_addr = 25'h103E9; dl_data = 8'h34;
        exp_mem.push_back({1'b1, 25'h103E9, 8'h34});
        @(negedge clk);
        dl_addr = 25'h103EA; dl_data = 8'h12;
        exp_mem.push_back({1'b1, 25'h103EA, 8'h12});
        @(negedge clk);
        dl_wr = 1'b0;
        wait_mem_idle("tail", 300, wok);
        check("tail_wait_high", wok, 1'b1);

        // Overflow: six pushes, memory never acks; only the first four are kept.
        ack_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) check("ovf_after_4th", dl_overflow, 1'b0);
            if (i == 5) check("ovf_after_5th", dl_overflow, 1'b1);
            dl_wr = 1'b1; dl_addr = 25'h200 + 25'(i); dl_data = 8'h40 + 8'(i);
            if (i < 4) exp_mem.push_back({1'b1, 25'h200 + 25'(i), 8'h40 + 8'(i)});
            @(negedge clk);
        end
        dl_wr = 1'b0;
        repeat (3) @(negedge clk);
        check("ovf_sticky_a", dl_overflow, 1'b1);

        // End of download with a CPU read waiting behind the drain and reset pulse.
        dl_downloading = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 25'h0ABCD; cpu_din = 8'h00;
        rd_val = 8'hC3;
        exp_mem.push_back({1'b0, 25'h0ABCD, 8'h00});
        exp_cpu.push_back(8'hC3);
        ack_delay = 2; ack_en = 1'b1;
        measure_pulse("rst_pulse", 16, qlen);
        check("drain_before_reset", qlen, 1);
        wait_cpu_ack("cpu_read1", 100);
        cpu_req = 1'b0;
        check("wait_released", cpu_wait, 1'b0);
        check("ovf_sticky_b", dl_overflow, 1'b1);
        wait_mem_idle("cpu1", 50, wok);

        // New download start clears the overflow flag; its end gives another pulse.
        dl_downloading = 1'b1;
        @(negedge clk);
        check("ovf_clear", dl_overflow, 1'b0);
        dl_downloading = 1'b0;
        measure_pulse("rst_pulse2", 16, qlen);
        repeat (3) @(negedge clk);
        check("wait_idle", cpu_wait, 1'b0);

        // CPU read in flight when a download starts: it completes, then the FIFO drains.
        ack_delay = 5; rd_val = 8'h5A;
        cpu_we = 1'b0; cpu_addr = 25'h08000; cpu_din = 8'h00;
        exp_mem.push_back({1'b0, 25'h08000, 8'h00});
        exp_cpu.push_back(8'h5A);
        cpu_req = 1'b1;
        g = 0;
        while (!mem_req && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("cpu_req_started", mem_req, 1'b1);
        dl_downloading = 1'b1;
        dl_wr = 1'b1; dl_addr = 25'h00100; dl_data = 8'h77;
        exp_mem.push_back({1'b1, 25'h00100, 8'h77});
        @(negedge clk);
        dl_wr = 1'b0;
        wait_cpu_ack("cpu_read2", 50);
        cpu_req = 1'b0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 25'h09000; cpu_din = 8'hEE;
        repeat (25) @(negedge clk);
        check("dl_after_cpu", exp_mem.size(), 0);
        check("wait_hold", cpu_wait, 1'b1);
        check("cpu_queue_empty", exp_cpu.size(), 0);
        cpu_req = 1'b0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time limit.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
